// File: rtl/stepper_pkg.sv
// stepper_pkg: shared profile-generator constants and the profile state encoding.
package stepper_pkg;
    localparam int CNT_W        = 16;
    localparam int START_PERIOD = 100;
    localparam int ACCEL_DEC    = 10;
    localparam int PULSE_W      = 4;

    typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, FIN} state_t;
endpackage

// File: rtl/step_period_timer.sv
// step_period_timer: free-running period counter that shapes the step pulse while a move runs.
module step_period_timer
    import stepper_pkg::*;
(
    input  logic             clk,
    input  logic             xres,
    input  logic             run,
    input  logic [CNT_W-1:0] period,
    output logic             step_out,
    output logic             step_tick,
    output logic             period_end
);
    logic [CNT_W-1:0] cnt;

    // Held at zero when idle so the first pulse starts right after the move begins.
    always_ff @(posedge clk or negedge xres) begin
        if (!xres) cnt <= '0;
        else cnt <= (!run || period_end) ? '0 : cnt + 1'b1;
    end

    assign step_tick  = run && cnt == '0;
    assign period_end = run && cnt == period - 1'b1;
    assign step_out   = run && cnt < CNT_W'(PULSE_W);
endmodule

// File: rtl/step_profile_gen.sv
// step_profile_gen: trapezoidal step clock and direction generator feeding the phase sequencer.
module step_profile_gen
    import stepper_pkg::*;
(
    input  logic             clk,
    input  logic             xres,
    input  logic             start,
    input  logic             dir_in,
    input  logic [CNT_W-1:0] step_num,
    input  logic [CNT_W-1:0] min_period,
    input  logic             stop,
    input  logic             abort,
    output logic             step_out,
    output logic             cw,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pos_cnt
);
    localparam logic [CNT_W-1:0] SP = CNT_W'(START_PERIOD);
    localparam logic [CNT_W-1:0] AD = CNT_W'(ACCEL_DEC);
    localparam logic [CNT_W-1:0] LO = CNT_W'(2 * PULSE_W);

    state_t           state;
    logic [CNT_W-1:0] remaining, acc, period, target;
    logic [CNT_W-1:0] target_in, up_period, dn_period, acc_dec, rem_min;
    logic             stop_l, step_tick, period_end, ramp_down;

    // Period steps saturate against START_PERIOD and the cruise target instead of wrapping.
    always_comb begin
        target_in = min_period < LO ? LO : (min_period > SP ? SP : min_period);
        up_period = (SP - period > AD) ? period + AD : SP;
        dn_period = (period - target > AD) ? period - AD : target;
        acc_dec   = (acc == '0) ? '0 : acc - 1'b1;
        rem_min   = (remaining < acc) ? remaining : acc;
        ramp_down = (state == ACCEL || state == CRUISE) && (remaining <= acc || stop_l || stop);
    end

    step_period_timer u_timer (
        .clk       (clk),
        .xres      (xres),
        .run       (busy),
        .period    (period),
        .step_out  (step_out),
        .step_tick (step_tick),
        .period_end(period_end)
    );

    always_ff @(posedge clk or negedge xres) begin
        if (!xres) begin
            state     <= IDLE;
            cw        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pos_cnt   <= '0;
            remaining <= '0;
            acc       <= '0;
            period    <= '0;
            target    <= '0;
            stop_l    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    stop_l <= 1'b0;
                    if (start) begin
                        cw        <= dir_in;
                        remaining <= step_num;
                        pos_cnt   <= '0;
                        acc       <= '0;
                        period    <= SP;
                        target    <= target_in;
                        state     <= (step_num == '0) ? FIN : ACCEL;
                        busy      <= step_num != '0;
                        done      <= step_num == '0;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    if (step_tick) begin
                        remaining <= remaining - 1'b1;
                        pos_cnt   <= pos_cnt + 1'b1;
                    end
                    if (stop && state != DECEL) stop_l <= 1'b1;
                    if (abort || (period_end && (remaining == '0 || (ramp_down && rem_min == '0)))) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (period_end && ramp_down) begin
                        state     <= DECEL;
                        remaining <= rem_min;
                        period    <= up_period;
                        acc       <= acc_dec;
                    end else if (period_end && state == ACCEL) begin
                        period <= dn_period;
                        acc    <= acc + 1'b1;
                        if (dn_period == target) state <= CRUISE;
                    end else if (period_end && state == DECEL) begin
                        period <= up_period;
                        acc    <= acc_dec;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_step_profile_gen.sv
// tb_step_profile_gen: directed profile checks with hand-computed step periods and counts.
module tb_step_profile_gen;
    logic        clk = 0, xres = 1, start = 0, dir_in = 0, stop = 0, abort = 0;
    logic [15:0] step_num = 0, min_period = 0;
    logic        step_out, cw, busy, done;
    logic [15:0] pos_cnt;
    int          vecs = 0, errs = 0, cyc = 0, done_cnt = 0, busy_cnt = 0, done_cyc = 0;
    int          r0 = 0, d0 = 0, b0 = 0, t0 = 0;
    logic        prev_step = 0;
    int          rises[$];

    step_profile_gen dut (
        .clk(clk), .xres(xres), .start(start), .dir_in(dir_in), .step_num(step_num),
        .min_period(min_period), .stop(stop), .abort(abort), .step_out(step_out),
        .cw(cw), .busy(busy), .done(done), .pos_cnt(pos_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_step <= step_out;
        if (step_out && !prev_step) rises.push_back(cyc);
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic start_move(input logic d, input int n, input int mp);
        r0 = rises.size();
        d0 = done_cnt;
        b0 = busy_cnt;
        dir_in = d;
        step_num = 16'(n);
        min_period = 16'(mp);
        start = 1;
        t0 = cyc;
        tick;
        start = 0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            tick;
            k++;
        end
        check("done_seen", done_cnt != d0, 1);
    endtask

    task automatic wait_rises(input int n, input int budget);
        int k = 0;
        while (rises.size() - r0 < n && k < budget) begin
            tick;
            k++;
        end
        check("rises_reached", rises.size() - r0 >= n, 1);
    endtask

    // Hand-derived period of step k for each scenario.
    function automatic int exp_p(input int kind, input int k);
        case (kind)
            1: return k <= 5 ? 110 - 10 * k : k <= 15 ? 50 : 50 + 10 * (k - 15);
            2: return k == 2 ? 90 : 100;
            3: return k <= 10 ? 110 - 10 * k : k <= 20 ? 8 : k == 30 ? 100 : 18 + 10 * (k - 21);
            4: return k <= 5 ? 110 - 10 * k : k <= 30 ? 50 : 60 + 10 * (k - 31);
            default: return 100;
        endcase
    endfunction

    task automatic verify(input string tag, input int kind, input int n, input int kfirst);
        check({tag, "_steps"}, rises.size() - r0, n);
        if (rises.size() - r0 == n) begin
            check({tag, "_first"}, rises[r0] - t0, 1);
            for (int k = kfirst; k < n; k++)
                check({tag, "_period"}, rises[r0 + k] - rises[r0 + k - 1], exp_p(kind, k));
            check({tag, "_last"}, done_cyc - rises[r0 + n - 1], exp_p(kind, n));
        end
        check({tag, "_pos"}, 32'(pos_cnt), n);
        check({tag, "_done1"}, done_cnt - d0, 1);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #2 xres = 0;
        #1;
        check("reset_outs", {step_out, busy, done, cw, pos_cnt}, 0);
        repeat (2) tick;
        xres = 1;
        tick;

        start_move(1, 20, 50);
        wait_done(3000);
        repeat (3) tick;
        verify("trap20", 1, 20, 1);
        check("trap20_cw", cw, 1);

        start_move(1, 3, 50);
        wait_done(1000);
        repeat (3) tick;
        verify("tri3", 2, 3, 1);

        start_move(0, 0, 50);
        check("zero_done_now", done, 1);
        check("zero_done_lat", done_cyc - t0, 1);
        repeat (3) tick;
        check("zero_done1", done_cnt - d0, 1);
        check("zero_no_steps", rises.size() - r0, 0);
        check("zero_no_busy", busy_cnt - b0, 0);
        check("zero_cw", cw, 0);
        check("zero_pos", 32'(pos_cnt), 0);

        start_move(1, 30, 0);
        wait_done(3000);
        repeat (3) tick;
        verify("clamp_lo", 3, 30, 1);

        start_move(1, 2, 500);
        wait_done(1000);
        repeat (3) tick;
        verify("clamp_hi", 5, 2, 1);

        start_move(1, 1000, 50);
        wait_rises(30, 3000);
        repeat (10) tick;
        stop = 1;
        tick;
        stop = 0;
        wait_done(3000);
        repeat (3) tick;
        verify("stop", 4, 35, 29);

        start_move(1, 100, 50);
        repeat (20) tick;
        dir_in = 0;
        step_num = 5;
        start = 1;
        tick;
        start = 0;
        wait_rises(7, 2000);
        tick;
        check("abort_mid_pulse", step_out, 1);
        abort = 1;
        tick;
        abort = 0;
        check("abort_drop", step_out, 0);
        check("abort_done", done, 1);
        tick;
        check("abort_done_once", done, 0);
        check("abort_idle", busy, 0);
        check("abort_pos", 32'(pos_cnt), 7);
        check("abort_cw_kept", cw, 1);

        start_move(1, 100, 50);
        wait_rises(8, 2000);
        tick;
        check("rst_busy_before", {busy, cw}, 2'b11);
        xres = 0;
        #1;
        check("rst_outs", {step_out, busy, done, cw, pos_cnt}, 0);
        tick;
        xres = 1;
        repeat (5) tick;
        check("rst_no_done", done_cnt - d0, 0);
        start_move(1, 3, 50);
        wait_done(1000);
        repeat (3) tick;
        verify("after_rst", 2, 3, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
